// File: rtl/rx_block_assembler.sv
// Packs a valid/ready byte stream into fixed-size blocks through a ping-pong buffer pair.
// Partial blocks are closed by an explicit flush or after an idle timeout.
module rx_block_assembler #(
    parameter int unsigned BLOCK_BYTES  = 64,
    parameter int unsigned IDLE_TIMEOUT = 2700000,
    parameter int unsigned LEN_W        = $clog2(BLOCK_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic [LEN_W-1:0]         blk_len,
    output logic                     blk_partial,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic                     overrun
);

    localparam int unsigned DW       = 8 * BLOCK_BYTES;
    localparam int unsigned TMR_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit          TMO_EN   = (IDLE_TIMEOUT != 0);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(IDLE_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMO_EN ? TMR_W'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BLOCK_BYTES);

    typedef enum logic [1:0] {
        StEmpty,
        StFilling,
        StFull
    } buf_state_e;

    buf_state_e       r_state [2];
    logic [DW-1:0]    r_buf   [2];
    logic [LEN_W-1:0] r_len   [2];
    logic             r_part  [2];
    logic             r_fill_ptr;
    logic             r_out_ptr;
    logic [LEN_W-1:0] r_count;
    logic [TMR_W-1:0] r_timer;
    logic             r_overrun;

    logic             w_accept;
    logic             w_hs;
    logic [LEN_W-1:0] w_count_inc;
    logic             w_full_close;
    logic             w_flush_close;
    logic             w_tmo_run;
    logic             w_tmo_close;
    logic             w_close;
    logic [LEN_W-1:0] w_close_len;
    logic [DW-1:0]    w_wr_mask;
    logic [DW-1:0]    w_wr_data;

    assign in_ready      = (r_state[r_fill_ptr] != StFull);
    assign w_accept      = in_valid && in_ready;
    assign blk_valid     = (r_state[r_out_ptr] == StFull);
    assign w_hs          = blk_valid && blk_ready;
    assign w_count_inc   = r_count + 1'b1;
    assign w_full_close  = w_accept && (w_count_inc == FULL_LEN);
    assign w_flush_close = flush && (w_accept || (r_count != '0));
    // An accepted byte always wins over an expiring timer.
    assign w_tmo_run     = TMO_EN && !w_accept && (r_count != '0);
    assign w_tmo_close   = w_tmo_run && (r_timer == TMR_LAST);
    assign w_close       = w_full_close || w_flush_close || w_tmo_close;
    assign w_close_len   = w_accept ? w_count_inc : r_count;

    assign blk_data    = blk_valid ? r_buf[r_out_ptr] : '0;
    assign blk_len     = blk_valid ? r_len[r_out_ptr] : '0;
    assign blk_partial = blk_valid && r_part[r_out_ptr];
    assign overrun     = r_overrun;

    // Byte k lands at the k-th byte lane counted from the MSB end.
    always_comb begin
        w_wr_mask = '0;
        w_wr_data = '0;
        for (int k = 0; k < int'(BLOCK_BYTES); k++) begin
            if (r_count == LEN_W'(k)) begin
                w_wr_mask[8*(int'(BLOCK_BYTES)-k)-1 -: 8] = 8'hFF;
                w_wr_data[8*(int'(BLOCK_BYTES)-k)-1 -: 8] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= StEmpty;
                r_buf[b]   <= '0;
                r_len[b]   <= '0;
                r_part[b]  <= 1'b0;
            end
            r_fill_ptr <= 1'b0;
            r_out_ptr  <= 1'b0;
            r_count    <= '0;
            r_timer    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                r_overrun <= 1'b1;
            end

            // The consumed buffer is never the fill target in the same cycle: a FULL fill
            // buffer blocks both accept and close.
            for (int b = 0; b < 2; b++) begin
                if (w_hs && (r_out_ptr == 1'(b))) begin
                    r_state[b] <= StEmpty;
                    r_buf[b]   <= '0;
                    r_len[b]   <= '0;
                    r_part[b]  <= 1'b0;
                end else if (r_fill_ptr == 1'(b)) begin
                    if (w_accept) begin
                        r_buf[b]   <= (r_buf[b] & ~w_wr_mask) | w_wr_data;
                        r_state[b] <= StFilling;
                    end
                    if (w_close) begin
                        r_state[b] <= StFull;
                        r_len[b]   <= w_close_len;
                        r_part[b]  <= (w_close_len != FULL_LEN);
                    end
                end
            end

            if (w_hs) begin
                r_out_ptr <= ~r_out_ptr;
            end

            if (w_close) begin
                r_fill_ptr <= ~r_fill_ptr;
                r_count    <= '0;
            end else if (w_accept) begin
                r_count <= w_count_inc;
            end

            if (w_accept || w_close) begin
                r_timer <= '0;
            end else if (w_tmo_run && (r_timer != TMR_MAX)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_block_assembler.sv
// Directed bench for rx_block_assembler: full blocks, backpressure/overrun, timeout,
// flush corner cases and mid-block reset.
module tb_rx_block_assembler;

    localparam int unsigned BB = 64;
    localparam int unsigned LW = $clog2(BB + 1);

    logic          clk;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [8*BB-1:0] blk_data;
    logic [LW-1:0] blk_len;
    logic          blk_partial;
    logic          blk_valid;
    logic          blk_ready;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    rx_block_assembler #(
        .BLOCK_BYTES (BB),
        .IDLE_TIMEOUT(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .blk_data   (blk_data),
        .blk_len    (blk_len),
        .blk_partial(blk_partial),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8*BB-1:0] obs,
                         input logic [8*BB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*BB-1:0] mk(input logic [7:0] start, input int n);
        logic [8*BB-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*(BB-k)-1 -: 8] = start + 8'(k);
        return v;
    endfunction

    task automatic send(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            in_data  = start + 8'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!blk_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    int n;
    int accepted;
    int drops;

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; blk_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", blk_valid, 0);
        check("rst_partial", blk_partial, 0);
        check("rst_overrun", overrun, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_len", blk_len, 0);
        check("rst_data", blk_data, 0);
        rst = 1'b0;

        // 64 back-to-back bytes, consumer always ready
        blk_ready = 1'b1;
        drops = 0;
        for (int i = 0; i < 64; i++) begin
            if (!in_ready) drops++;
            if (i == 63) check("full_early_valid", blk_valid, 0);
            in_data = 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("full_valid", blk_valid, 1);
        check("full_len", blk_len, 64);
        check("full_partial", blk_partial, 0);
        check("full_data", blk_data, mk(8'h00, 64));
        check("full_byte0", blk_data[511:504], 8'h00);
        check("full_byte63", blk_data[7:0], 8'h3F);
        check("full_no_drop", drops, 0);
        tick();
        check("full_consumed", blk_valid, 0);

        // 192 bytes with the consumer stalled
        blk_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 192; i++) begin
            if (in_ready) accepted++;
            if (i == 150) check("stall_hold_mid", blk_data, mk(8'h00, 64));
            in_data = 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("stall_accepted", accepted, 128);
        check("stall_overrun", overrun, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", blk_valid, 1);
        check("stall_len", blk_len, 64);
        check("stall_hold_end", blk_data, mk(8'h00, 64));
        blk_ready = 1'b1;
        tick();
        check("stall_second_valid", blk_valid, 1);
        check("stall_second_data", blk_data, mk(8'h40, 64));
        check("stall_ready_back", in_ready, 1);
        tick();
        check("stall_drained", blk_valid, 0);
        check("overrun_sticky", overrun, 1);

        // Idle timeout after 5 bytes
        send(8'hA1, 5);
        wait_valid(n);
        check("tmo_latency", n, 100);
        check("tmo_len", blk_len, 5);
        check("tmo_partial", blk_partial, 1);
        check("tmo_data", blk_data, mk(8'hA1, 5));
        tick();

        // Byte on the exact expiry cycle restarts the timer
        send(8'hB1, 3);
        for (int i = 0; i < 99; i++) tick();
        check("tmo_edge_no_early", blk_valid, 0);
        in_data = 8'hB4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("tmo_edge_no_close", blk_valid, 0);
        wait_valid(n);
        check("tmo_edge_restart", n, 100);
        check("tmo_edge_len", blk_len, 4);
        check("tmo_edge_data", blk_data, mk(8'hB1, 4));
        tick();

        // Flush with empty buffer
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_a", blk_valid, 0);
        tick();
        check("flush_empty_b", blk_valid, 0);

        // Flush alongside a byte in a partial block
        send(8'hD1, 2);
        in_data = 8'hD3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_byte_valid", blk_valid, 1);
        check("flush_byte_len", blk_len, 3);
        check("flush_byte_partial", blk_partial, 1);
        check("flush_byte_data", blk_data, mk(8'hD1, 3));
        tick();

        // Flush alongside the 64th byte: one full block
        send(8'hC0, 63);
        in_data = 8'hFF; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush64_valid", blk_valid, 1);
        check("flush64_len", blk_len, 64);
        check("flush64_partial", blk_partial, 0);
        check("flush64_data", blk_data, mk(8'hC0, 64));
        tick();
        check("flush64_single", blk_valid, 0);
        tick();
        check("flush64_single_b", blk_valid, 0);

        // Reset mid-block
        send(8'h10, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", blk_valid, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_len", blk_len, 0);
        send(8'h80, 64);
        check("mrst_block_valid", blk_valid, 1);
        check("mrst_block_len", blk_len, 64);
        check("mrst_block_data", blk_data, mk(8'h80, 64));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
